id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
ID/EX pipeline stage that registers decoded operands and control, and drives the execute-stage ALU inputs (alu_control, a, b).
- Resolves RAW hazards: forwards EX/MEM and MEM/WB results onto the ALU operands.
- Inserts a one-cycle bubble on load-use hazards.
- Honours downstream stall and branch flush.
- Sits between decode/register-file read and the ALU.

Parameters:
WIDTH, 32, datapath width
CTRL_WIDTH, 3, ALU control width (000 ADD … 111 SRL)
REG_ADDR_WIDTH, 5, register address width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
id_valid  input  1  decode holds a valid instruction
id_ready  output  1  stage accepts the decode instruction this cycle
id_rs1_addr, id_rs2_addr  input  REG_ADDR_WIDTH  source register addresses
id_rs1_data, id_rs2_data  input  WIDTH  register-file read data
id_imm  input  WIDTH  sign-extended immediate
id_alu_src  input  1  1: operand b = immediate
id_alu_control  input  CTRL_WIDTH  ALU opcode
id_rd_addr  input  REG_ADDR_WIDTH  destination register
id_reg_write  input  1  instruction writes rd
id_mem_read  input  1  instruction is a load
stall  input  1  downstream hold request
flush  input  1  kill instruction in EX (taken branch/jump)
ex_mem_rd_addr  input  REG_ADDR_WIDTH  EX/MEM destination
ex_mem_reg_write  input  1  EX/MEM writes rd
ex_mem_result  input  WIDTH  EX/MEM ALU result
mem_wb_rd_addr  input  REG_ADDR_WIDTH  MEM/WB destination
mem_wb_reg_write  input  1  MEM/WB writes rd
mem_wb_result  input  WIDTH  MEM/WB writeback data
ex_valid  output  1  EX holds a valid instruction
alu_control  output  CTRL_WIDTH  to ALU
alu_a, alu_b  output  WIDTH  ALU operands after forwarding/immediate select
store_data  output  WIDTH  forwarded rs2 value
ex_rd_addr  output  REG_ADDR_WIDTH  registered destination
ex_reg_write, ex_mem_read  output  1  registered control, gated by ex_valid
stall_count, bubble_count  output  32  performance counters (see Optional Feature)

Behaviour:
- Reset (rst_n low, async):
  - all pipeline registers clear to 0.
  - ex_valid=0, ex_reg_write=0, ex_mem_read=0, alu_control=000, ex_rd_addr=0.
  - counters=0.
- Latency: 1 cycle from decode acceptance to ALU operands.
- load_use = ex_valid & ex_mem_read & (ex_rd_addr≠0) & id_valid & (id_rs1_addr==ex_rd_addr | id_rs2_addr==ex_rd_addr).
- id_ready = ~stall & ~load_use. This is combinational. A flush does not block acceptance: the wrong-path decode instruction is consumed and discarded.
- Register update priority per rising edge, highest first:
  1. flush: ex_valid←0; ex_reg_write←0; ex_mem_read←0. Applies even while stall=1.
  2. stall: all registers hold. load_use is ignored.
  3. load_use: insert bubble (ex_valid←0, controls←0). Decode holds its instruction, which is accepted the next cycle.
  4. id_valid: load all id_* fields; ex_valid←1.
  5. otherwise: bubble.
- Forwarding, combinational from registered rs addresses; applied to rs1 → alu_a and rs2 → store_data/alu_b:
  - EX/MEM match (reg_write & rd≠0 & rd==rs): select ex_mem_result.
  - else MEM/WB match: select mem_wb_result.
  - else registered read data.
  - EX/MEM wins when both match. Register x0 is never forwarded.
- alu_b = ex_alu_src ? registered imm : forwarded rs2.
- When ex_valid=0: ex_reg_write and ex_mem_read outputs are 0. alu_a/alu_b may hold stale data.
- Back-to-back loads to the same rd: each load_use produces exactly one bubble.

Optional Feature:
ID_EX_PERF_CNT_EN
- Defined:
  - stall_count increments on every cycle with stall=1 and rst_n high.
  - bubble_count increments on every load_use or flush cycle.
  - Both are 32-bit and wrap from FFFF_FFFF to 0.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Reset mid-operation: assert rst_n=0 while ex_valid=1 → ex_valid=0, ex_reg_write=0 immediately (async), without waiting for a clock edge.
- ADD x3,x1,x2 with id_rs1_data=5, id_rs2_data=7; next cycle ex_mem_rd_addr=1, ex_mem_result=100, mem_wb_rd_addr=1, mem_wb_result=200 → alu_a=100, alu_b=7, alu_control=000.
- Load to x4 in EX, decode rs2=x4, id_valid=1 → id_ready=0 for 1 cycle, one bubble (ex_valid=0), instruction enters EX next cycle; bubble_count=1 with macro.
- Forwarding to x0: ex_mem_rd_addr=0, ex_mem_reg_write=1, rs1=x0, id_rs1_data=0 → alu_a=0.
- Stall held 3 cycles with flush asserted in cycle 2 → registers hold in cycle 1, ex_valid=0 after cycle 2, id_ready=0 throughout; stall_count=3 with macro.
- id_alu_src=1, id_imm=FFFF_FFF0, alu_control=001 → alu_b=FFFF_FFF0; store_data=forwarded rs2.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding, load-use bubble insertion,
// stall/flush handling. Define ID_EX_PERF_CNT_EN to build the stall/bubble performance counters.
module id_ex_stage #(
    parameter int WIDTH          = 32,
    parameter int CTRL_WIDTH     = 3,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    output logic                      id_ready,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic [WIDTH-1:0]          id_rs1_data,
    input  logic [WIDTH-1:0]          id_rs2_data,
    input  logic [WIDTH-1:0]          id_imm,
    input  logic                      id_alu_src,
    input  logic [CTRL_WIDTH-1:0]     id_alu_control,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [REG_ADDR_WIDTH-1:0] ex_mem_rd_addr,
    input  logic                      ex_mem_reg_write,
    input  logic [WIDTH-1:0]          ex_mem_result,
    input  logic [REG_ADDR_WIDTH-1:0] mem_wb_rd_addr,
    input  logic                      mem_wb_reg_write,
    input  logic [WIDTH-1:0]          mem_wb_result,
    output logic                      ex_valid,
    output logic [CTRL_WIDTH-1:0]     alu_control,
    output logic [WIDTH-1:0]          alu_a,
    output logic [WIDTH-1:0]          alu_b,
    output logic [WIDTH-1:0]          store_data,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    output logic                      ex_reg_write,
    output logic                      ex_mem_read,
    output logic [31:0]               stall_count,
    output logic [31:0]               bubble_count
);

    logic                      ex_valid_q,    ex_valid_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr_q,    rs1_addr_d;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr_q,    rs2_addr_d;
    logic [WIDTH-1:0]          rs1_data_q,    rs1_data_d;
    logic [WIDTH-1:0]          rs2_data_q,    rs2_data_d;
    logic [WIDTH-1:0]          imm_q,         imm_d;
    logic                      alu_src_q,     alu_src_d;
    logic [CTRL_WIDTH-1:0]     alu_control_q, alu_control_d;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q,     rd_addr_d;
    logic                      reg_write_q,   reg_write_d;
    logic                      mem_read_q,    mem_read_d;

    logic            load_use;
    logic [WIDTH-1:0] rs1_fwd;
    logic [WIDTH-1:0] rs2_fwd;

    // A load in EX cannot supply its data in time for a dependent instruction in decode.
    assign load_use = ex_valid_q & mem_read_q & (rd_addr_q != '0) & id_valid &
                      ((id_rs1_addr == rd_addr_q) | (id_rs2_addr == rd_addr_q));

    assign id_ready = ~stall & ~load_use;

    always_comb begin
        ex_valid_d    = ex_valid_q;
        rs1_addr_d    = rs1_addr_q;
        rs2_addr_d    = rs2_addr_q;
        rs1_data_d    = rs1_data_q;
        rs2_data_d    = rs2_data_q;
        imm_d         = imm_q;
        alu_src_d     = alu_src_q;
        alu_control_d = alu_control_q;
        rd_addr_d     = rd_addr_q;
        reg_write_d   = reg_write_q;
        mem_read_d    = mem_read_q;
        if (flush) begin
            ex_valid_d  = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
        end else if (stall) begin
            ex_valid_d = ex_valid_q;
        end else if (id_valid && !load_use) begin
            ex_valid_d    = 1'b1;
            rs1_addr_d    = id_rs1_addr;
            rs2_addr_d    = id_rs2_addr;
            rs1_data_d    = id_rs1_data;
            rs2_data_d    = id_rs2_data;
            imm_d         = id_imm;
            alu_src_d     = id_alu_src;
            alu_control_d = id_alu_control;
            rd_addr_d     = id_rd_addr;
            reg_write_d   = id_reg_write;
            mem_read_d    = id_mem_read;
        end else begin
            ex_valid_d    = 1'b0;
            alu_src_d     = 1'b0;
            alu_control_d = '0;
            reg_write_d   = 1'b0;
            mem_read_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            rs1_addr_q    <= '0;
            rs2_addr_q    <= '0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            imm_q         <= '0;
            alu_src_q     <= 1'b0;
            alu_control_q <= '0;
            rd_addr_q     <= '0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            rs1_addr_q    <= rs1_addr_d;
            rs2_addr_q    <= rs2_addr_d;
            rs1_data_q    <= rs1_data_d;
            rs2_data_q    <= rs2_data_d;
            imm_q         <= imm_d;
            alu_src_q     <= alu_src_d;
            alu_control_q <= alu_control_d;
            rd_addr_q     <= rd_addr_d;
            reg_write_q   <= reg_write_d;
            mem_read_q    <= mem_read_d;
        end
    end

    // The younger EX/MEM result takes precedence; x0 is hardwired and never forwarded.
    function automatic logic [WIDTH-1:0] forward(input logic [REG_ADDR_WIDTH-1:0] rs,
                                                 input logic [WIDTH-1:0]          rf_data);
        if (ex_mem_reg_write && (ex_mem_rd_addr != '0) && (ex_mem_rd_addr == rs))
            return ex_mem_result;
        else if (mem_wb_reg_write && (mem_wb_rd_addr != '0) && (mem_wb_rd_addr == rs))
            return mem_wb_result;
        else
            return rf_data;
    endfunction

    assign rs1_fwd = forward(rs1_addr_q, rs1_data_q);
    assign rs2_fwd = forward(rs2_addr_q, rs2_data_q);

    assign ex_valid     = ex_valid_q;
    assign alu_control  = alu_control_q;
    assign alu_a        = rs1_fwd;
    assign alu_b        = alu_src_q ? imm_q : rs2_fwd;
    assign store_data   = rs2_fwd;
    assign ex_rd_addr   = rd_addr_q;
    assign ex_reg_write = reg_write_q & ex_valid_q;
    assign ex_mem_read  = mem_read_q & ex_valid_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_count_q,  stall_count_d;
    logic [31:0] bubble_count_q, bubble_count_d;

    always_comb begin
        stall_count_d  = stall_count_q + (stall ? 32'd1 : 32'd0);
        bubble_count_d = bubble_count_q + ((load_use | flush) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q  <= '0;
            bubble_count_q <= '0;
        end else begin
            stall_count_q  <= stall_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign stall_count  = stall_count_q;
    assign bubble_count = bubble_count_q;
`else
    assign stall_count  = '0;
    assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, forwarding, load-use bubble,
// stall/flush interaction, immediate select and (with ID_EX_PERF_CNT_EN) the counters.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_rs1_addr, id_rs2_addr;
    logic [31:0] id_rs1_data, id_rs2_data;
    logic [31:0] id_imm;
    logic        id_alu_src;
    logic [2:0]  id_alu_control;
    logic [4:0]  id_rd_addr;
    logic        id_reg_write, id_mem_read;
    logic        stall, flush;
    logic [4:0]  ex_mem_rd_addr;
    logic        ex_mem_reg_write;
    logic [31:0] ex_mem_result;
    logic [4:0]  mem_wb_rd_addr;
    logic        mem_wb_reg_write;
    logic [31:0] mem_wb_result;
    logic        ex_valid;
    logic [2:0]  alu_control;
    logic [31:0] alu_a, alu_b, store_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write, ex_mem_read;
    logic [31:0] stall_count, bubble_count;

    int compared_cnt   = 0;
    int mismatched_cnt = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_alu_src(id_alu_src), .id_alu_control(id_alu_control),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .stall(stall), .flush(flush),
        .ex_mem_rd_addr(ex_mem_rd_addr), .ex_mem_reg_write(ex_mem_reg_write),
        .ex_mem_result(ex_mem_result),
        .mem_wb_rd_addr(mem_wb_rd_addr), .mem_wb_reg_write(mem_wb_reg_write),
        .mem_wb_result(mem_wb_result),
        .ex_valid(ex_valid), .alu_control(alu_control),
        .alu_a(alu_a), .alu_b(alu_b), .store_data(store_data),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .stall_count(stall_count), .bubble_count(bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared_cnt++;
        assert (observed === expected)
        else begin
            mismatched_cnt++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [31:0] imm, input logic src, input logic [2:0] ctl,
                                 input logic [4:0] rd, input logic rw, input logic mr);
        id_valid       = v;
        id_rs1_addr    = rs1;
        id_rs2_addr    = rs2;
        id_rs1_data    = d1;
        id_rs2_data    = d2;
        id_imm         = imm;
        id_alu_src     = src;
        id_alu_control = ctl;
        id_rd_addr     = rd;
        id_reg_write   = rw;
        id_mem_read    = mr;
    endtask

    task automatic setForward(input logic [4:0] emr, input logic emw, input logic [31:0] emd,
                              input logic [4:0] mwr, input logic mww, input logic [31:0] mwd);
        ex_mem_rd_addr   = emr;
        ex_mem_reg_write = emw;
        ex_mem_result    = emd;
        mem_wb_rd_addr   = mwr;
        mem_wb_reg_write = mww;
        mem_wb_result    = mwd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        applyStimulus(1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
        setForward(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        #2;
        checkOutput("reset_ex_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("reset_reg_write", {31'b0, ex_reg_write}, 32'd0);
        checkOutput("reset_mem_read", {31'b0, ex_mem_read}, 32'd0);
        checkOutput("reset_alu_control", {29'b0, alu_control}, 32'd0);
        checkOutput("reset_rd_addr", {27'b0, ex_rd_addr}, 32'd0);
        checkOutput("reset_stall_count", stall_count, 32'd0);
        checkOutput("reset_bubble_count", bubble_count, 32'd0);
        checkOutput("reset_id_ready", {31'b0, id_ready}, 32'd1);
        #1 rst_n = 1'b1;

        // ADD x3,x1,x2 then forwarding priority on rs1
        applyStimulus(1'b1, 5'd1, 5'd2, 32'd5, 32'd7, 32'h0, 1'b0, 3'b000, 5'd3, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
        setForward(5'd1, 1'b1, 32'd100, 5'd1, 1'b1, 32'd200);
        #1;
        checkOutput("add_ex_valid", {31'b0, ex_valid}, 32'd1);
        checkOutput("add_alu_a_exmem", alu_a, 32'd100);
        checkOutput("add_alu_b", alu_b, 32'd7);
        checkOutput("add_alu_control", {29'b0, alu_control}, 32'd0);
        checkOutput("add_rd_addr", {27'b0, ex_rd_addr}, 32'd3);
        checkOutput("add_reg_write", {31'b0, ex_reg_write}, 32'd1);
        setForward(5'd1, 1'b0, 32'd100, 5'd1, 1'b1, 32'd200);
        #1 checkOutput("add_alu_a_memwb", alu_a, 32'd200);
        setForward(5'd1, 1'b0, 32'd100, 5'd2, 1'b1, 32'd200);
        #1 checkOutput("add_alu_a_rf", alu_a, 32'd5);
        checkOutput("add_alu_b_memwb", alu_b, 32'd200);
        checkOutput("add_store_memwb", store_data, 32'd200);

        // Asynchronous reset while EX holds a valid instruction
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("async_rst_reg_write", {31'b0, ex_reg_write}, 32'd0);
        rst_n = 1'b1;
        setForward(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);

        // Load x4, then dependent ADD x9,x7,x4
        applyStimulus(1'b1, 5'd5, 5'd6, 32'd1, 32'd2, 32'd8, 1'b1, 3'b000, 5'd4, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 5'd7, 5'd4, 32'd11, 32'd22, 32'h0, 1'b0, 3'b000, 5'd9, 1'b1, 1'b0);
        #1;
        checkOutput("lu_ex_mem_read", {31'b0, ex_mem_read}, 32'd1);
        checkOutput("lu_id_ready_low", {31'b0, id_ready}, 32'd0);
        tick();
        checkOutput("lu_bubble_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("lu_bubble_mem_read", {31'b0, ex_mem_read}, 32'd0);
        checkOutput("lu_id_ready_high", {31'b0, id_ready}, 32'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("lu_enter_valid", {31'b0, ex_valid}, 32'd1);
        checkOutput("lu_enter_rd", {27'b0, ex_rd_addr}, 32'd9);
        checkOutput("lu_enter_alu_a", alu_a, 32'd11);
`ifdef ID_EX_PERF_CNT_EN
        checkOutput("lu_bubble_count", bubble_count, 32'd1);
`else
        checkOutput("lu_bubble_count", bubble_count, 32'd0);
`endif

        // x0 is never forwarded
        applyStimulus(1'b1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 3'b010, 5'd5, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
        setForward(5'd0, 1'b1, 32'hDEAD_0001, 5'd0, 1'b1, 32'hBEEF_0002);
        #1;
        checkOutput("x0_alu_a", alu_a, 32'd0);
        checkOutput("x0_store_data", store_data, 32'd0);
        setForward(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);

        // Stall for three cycles with a flush in the second
        applyStimulus(1'b1, 5'd10, 5'd11, 32'h33, 32'h44, 32'h0, 1'b0, 3'b011, 5'd12, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd13, 5'd14, 32'h55, 32'h66, 32'h0, 1'b0, 3'b100, 5'd13, 1'b1, 1'b0);
        stall = 1'b1;
        #1 checkOutput("stall_id_ready_c0", {31'b0, id_ready}, 32'd0);
        tick();
        checkOutput("stall_hold_valid", {31'b0, ex_valid}, 32'd1);
        checkOutput("stall_hold_rd", {27'b0, ex_rd_addr}, 32'd12);
        checkOutput("stall_hold_alu_a", alu_a, 32'h33);
        checkOutput("stall_id_ready_c1", {31'b0, id_ready}, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("stall_flush_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("stall_flush_reg_write", {31'b0, ex_reg_write}, 32'd0);
        checkOutput("stall_id_ready_c2", {31'b0, id_ready}, 32'd0);
        tick();
        stall = 1'b0;
        checkOutput("stall_c3_valid", {31'b0, ex_valid}, 32'd0);
`ifdef ID_EX_PERF_CNT_EN
        checkOutput("stall_count", stall_count, 32'd3);
        checkOutput("stall_bubble_count", bubble_count, 32'd2);
`else
        checkOutput("stall_count", stall_count, 32'd0);
        checkOutput("stall_bubble_count", bubble_count, 32'd0);
`endif
        #1 checkOutput("stall_release_ready", {31'b0, id_ready}, 32'd1);
        tick();
        checkOutput("stall_accept_valid", {31'b0, ex_valid}, 32'd1);
        checkOutput("stall_accept_rd", {27'b0, ex_rd_addr}, 32'd13);
        checkOutput("stall_accept_ctl", {29'b0, alu_control}, 32'd4);

        // Immediate operand with forwarded store data
        applyStimulus(1'b1, 5'd15, 5'd14, 32'h77, 32'h99, 32'hFFFF_FFF0, 1'b1, 3'b001, 5'd16, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
        setForward(5'd14, 1'b1, 32'h0000_1234, 5'd0, 1'b0, 32'h0);
        #1;
        checkOutput("imm_alu_b", alu_b, 32'hFFFF_FFF0);
        checkOutput("imm_store_data", store_data, 32'h0000_1234);
        checkOutput("imm_alu_control", {29'b0, alu_control}, 32'd1);
        checkOutput("imm_alu_a", alu_a, 32'h77);
        setForward(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);

        // Flush without stall consumes and discards the decode instruction
        applyStimulus(1'b1, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 1'b0, 3'b000, 5'd17, 1'b1, 1'b0);
        flush = 1'b1;
        #1 checkOutput("flush_id_ready", {31'b0, id_ready}, 32'd1);
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("flush_ex_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("flush_reg_write", {31'b0, ex_reg_write}, 32'd0);
`ifdef ID_EX_PERF_CNT_EN
        checkOutput("flush_bubble_count", bubble_count, 32'd3);
`else
        checkOutput("flush_bubble_count", bubble_count, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatched_cnt);
        $finish;
    end

endmodule
